// File: rtl/bd_wr_filter.sv
// BD write filter: matches 32-byte BD writes against four ring windows, forwards hits
// through a single output register and tracks outstanding BDs per ring.
module bd_wr_filter #(
   parameter int DATA_W    = 256,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 user_clk,
   input  logic                 user_reset,
   input  logic [107:0]         win_base,
   input  logic [107:0]         win_high,
   input  logic [107:0]         win_size,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [31:0]          req_addr,
   input  logic [DATA_W-1:0]    req_data,
   output logic                 bd_wr_valid,
   input  logic                 bd_wr_ready,
   output logic [1:0]           bd_wr_ch,
   output logic [26:0]          bd_wr_idx,
   output logic [DATA_W-1:0]    bd_wr_data,
   input  logic [3:0]           bd_consume,
   output logic [111:0]         bd_cnt,
   output logic                 err_miss,
   output logic                 err_ovf,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef logic [26:0] bd_page_t;
   typedef logic [27:0] bd_cnt_t;

   localparam logic [ERR_CNT_W-1:0] ERR_ONE = 1;

   bd_page_t base [4];
   bd_page_t high [4];
   bd_page_t size [4];

   bd_cnt_t  cnt_q [4];
   bd_cnt_t  cnt_d [4];

   logic                 valid_q, valid_d;
   logic [1:0]           ch_q, ch_d;
   bd_page_t             idx_q, idx_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic                 miss_q, miss_d;
   logic                 ovf_q, ovf_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   bd_page_t page;
   logic     aligned;
   logic     hit_any;
   logic [1:0] hit_ch;
   bd_cnt_t  cap;
   logic     full;
   logic     accept;
   logic     load;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         base[i] = win_base[27*i +: 27];
         high[i] = win_high[27*i +: 27];
         size[i] = win_size[27*i +: 27];
         bd_cnt[28*i +: 28] = cnt_q[i];
      end
   end

   assign req_ready = ~user_reset & (~valid_q | bd_wr_ready);
   assign accept    = req_valid & req_ready;
   assign page      = req_addr[31:5];
   assign aligned   = (req_addr[4:0] == 5'd0);

   // Scan from the top so the lowest matching window is the last one written.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hit_any = 1'b0;
      hit_ch  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (aligned && (page >= base[i]) && (page <= high[i])) begin
            hit_any = 1'b1;
            hit_ch  = 2'(i);
         end
      end
   end

   assign cap  = {1'b0, size[hit_ch]} + 28'd1;
   assign full = (cnt_q[hit_ch] >= cap);
   assign load = accept & hit_any & ~full;

   always_comb begin
      valid_d = valid_q;
      ch_d    = ch_q;
      idx_d   = idx_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         ch_d    = hit_ch;
         idx_d   = page - base[hit_ch];
         data_d  = req_data;
      end else if (bd_wr_ready) begin
         valid_d = 1'b0;
      end
   end

   always_comb begin
      miss_d    = accept & ~hit_any;
      ovf_d     = accept & hit_any & full;
      err_cnt_d = err_cnt_q;
      if ((miss_d || ovf_d) && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + ERR_ONE;
   end

   // A consume on an empty ring is ignored; a simultaneous write and consume cancel.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         logic inc, dec;
         inc      = load && (hit_ch == 2'(i));
         dec      = bd_consume[i] && (cnt_q[i] != 28'd0);
         cnt_d[i] = cnt_q[i];
         if (inc && !dec)
            cnt_d[i] = cnt_q[i] + 28'd1;
         else if (dec && !inc)
            cnt_d[i] = cnt_q[i] - 28'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the wide data register
   // is reset too because its value is visible on bd_wr_data straight after reset.
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         valid_q   <= 1'b0;
         ch_q      <= 2'd0;
         idx_q     <= '0;
         data_q    <= '0;
         miss_q    <= 1'b0;
         ovf_q     <= 1'b0;
         err_cnt_q <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         valid_q   <= valid_d;
         ch_q      <= ch_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         miss_q    <= miss_d;
         ovf_q     <= ovf_d;
         err_cnt_q <= err_cnt_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign bd_wr_valid = valid_q;
   assign bd_wr_ch    = ch_q;
   assign bd_wr_idx   = idx_q;
   assign bd_wr_data  = data_q;
   assign err_miss    = miss_q;
   assign err_ovf     = ovf_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_bd_wr_filter.sv
// Directed bench for bd_wr_filter: hand-computed expectations checked with immediate assertions.
module tb_bd_wr_filter;

   localparam int DATA_W    = 256;
   localparam int ERR_CNT_W = 16;

   logic                 user_clk;
   logic                 user_reset;
   logic [107:0]         win_base, win_high, win_size;
   logic                 req_valid, req_ready;
   logic [31:0]          req_addr;
   logic [DATA_W-1:0]    req_data;
   logic                 bd_wr_valid, bd_wr_ready;
   logic [1:0]           bd_wr_ch;
   logic [26:0]          bd_wr_idx;
   logic [DATA_W-1:0]    bd_wr_data;
   logic [3:0]           bd_consume;
   logic [111:0]         bd_cnt;
   logic                 err_miss, err_ovf;
   logic [ERR_CNT_W-1:0] err_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   bd_wr_filter #(.DATA_W(DATA_W), .ERR_CNT_W(ERR_CNT_W)) dut (
      .user_clk   (user_clk),
      .user_reset (user_reset),
      .win_base   (win_base),
      .win_high   (win_high),
      .win_size   (win_size),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .bd_wr_valid(bd_wr_valid),
      .bd_wr_ready(bd_wr_ready),
      .bd_wr_ch   (bd_wr_ch),
      .bd_wr_idx  (bd_wr_idx),
      .bd_wr_data (bd_wr_data),
      .bd_consume (bd_consume),
      .bd_cnt     (bd_cnt),
      .err_miss   (err_miss),
      .err_ovf    (err_ovf),
      .err_cnt    (err_cnt)
   );

   initial user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   initial begin
      #200000;
      $display("FAIL timeout: observed no end of stimulus, required finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   task automatic set_win(input int i, input logic [26:0] b, input logic [26:0] h, input logic [26:0] s);
      win_base[27*i +: 27] = b;
      win_high[27*i +: 27] = h;
      win_size[27*i +: 27] = s;
   endtask

   function automatic logic [DATA_W-1:0] mk(input int k);
      return {8{32'hD000_0000 + 32'(k)}};
   endfunction

   function automatic logic [27:0] cnt_of(input int i);
      return bd_cnt[28*i +: 28];
   endfunction

   initial begin
      user_reset  = 1'b1;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_data    = '0;
      bd_wr_ready = 1'b0;
      bd_consume  = 4'b0;
      for (int i = 0; i < 4; i++) set_win(i, 27'h1, 27'h0, 27'h0);

      // Reset state
      tick();
      tick();
      check("rst_ready_low", req_ready, 0);
      check("rst_valid", bd_wr_valid, 0);
      user_reset = 1'b0;
      #1;
      check("post_rst_ready", req_ready, 1);
      check("post_rst_cnt", bd_cnt, 0);
      check("post_rst_errcnt", err_cnt, 0);
      check("post_rst_errs", {err_miss, err_ovf}, 0);

      // 1: single hit on ring 0
      set_win(0, 27'h100, 27'h1FF, 27'd3);
      req_valid = 1'b1; req_addr = 32'h2020; req_data = mk(1); bd_wr_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      check("t1_valid", bd_wr_valid, 1);
      check("t1_ch", bd_wr_ch, 0);
      check("t1_idx", bd_wr_idx, 1);
      check("t1_data", bd_wr_data, mk(1));
      check("t1_cnt0", cnt_of(0), 1);
      bd_consume = 4'b0001;
      tick();
      bd_consume = 4'b0000;
      check("t1_valid_clr", bd_wr_valid, 0);
      check("t1_cnt0_consumed", cnt_of(0), 0);

      // 2: back-to-back fill of ring 0, then overflow
      for (int k = 0; k < 4; k++) begin
         req_valid = 1'b1; req_addr = 32'h2000 + 32'(32 * k); req_data = mk(10 + k);
         #1;
         check("t2_ready", req_ready, 1);
         tick();
         check("t2_valid", bd_wr_valid, 1);
         check("t2_idx", bd_wr_idx, 27'(k));
         check("t2_data", bd_wr_data, mk(10 + k));
      end
      check("t2_cnt0_full", cnt_of(0), 4);
      req_addr = 32'h2080; req_data = mk(14);
      #1;
      check("t2_ovf_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      check("t2_ovf_pulse", err_ovf, 1);
      check("t2_ovf_errcnt", err_cnt, 1);
      check("t2_ovf_novalid", bd_wr_valid, 0);
      check("t2_ovf_cnt0", cnt_of(0), 4);
      tick();
      check("t2_ovf_clear", err_ovf, 0);
      bd_consume = 4'b0001;
      repeat (4) tick();
      bd_consume = 4'b0000;
      check("t2_drained", cnt_of(0), 0);

      // 3: backpressure holds the output register and stalls the request
      bd_wr_ready = 1'b0;
      req_valid = 1'b1; req_addr = 32'h2000; req_data = mk(20);
      tick();
      check("t3_valid", bd_wr_valid, 1);
      req_addr = 32'h2020; req_data = mk(21);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t3_stall_ready", req_ready, 0);
         check("t3_hold_data", bd_wr_data, mk(20));
         check("t3_hold_idx", bd_wr_idx, 0);
         tick();
      end
      bd_wr_ready = 1'b1;
      #1;
      check("t3_ready_rise", req_ready, 1);
      tick();
      req_valid = 1'b0;
      check("t3_next_valid", bd_wr_valid, 1);
      check("t3_next_idx", bd_wr_idx, 1);
      check("t3_next_data", bd_wr_data, mk(21));
      check("t3_cnt0", cnt_of(0), 2);
      tick();
      check("t3_drained_out", bd_wr_valid, 0);

      // 4: window miss and misaligned address
      req_valid = 1'b1; req_addr = 32'h5000;
      tick();
      req_addr = 32'h2024;
      check("t4_miss1", err_miss, 1);
      check("t4_miss1_errcnt", err_cnt, 2);
      check("t4_miss1_novalid", bd_wr_valid, 0);
      tick();
      req_valid = 1'b0;
      check("t4_miss2", err_miss, 1);
      check("t4_miss2_errcnt", err_cnt, 3);
      check("t4_miss2_novalid", bd_wr_valid, 0);
      tick();
      check("t4_miss_clear", err_miss, 0);
      check("t4_cnt_same", bd_cnt, {28'd0, 28'd0, 28'd0, 28'd2});

      // 5: simultaneous write and consume; full check ignores a same-cycle consume
      set_win(2, 27'h400, 27'h4FF, 27'd7);
      req_valid = 1'b1; req_addr = 32'h8000; req_data = mk(30);
      tick();
      req_addr = 32'h8020; req_data = mk(31);
      tick();
      check("t5_ch2", bd_wr_ch, 2);
      check("t5_idx1", bd_wr_idx, 1);
      check("t5_cnt2", cnt_of(2), 2);
      req_addr = 32'h8040; req_data = mk(32); bd_consume = 4'b0100;
      tick();
      req_valid = 1'b0; bd_consume = 4'b0000;
      check("t5_both_valid", bd_wr_valid, 1);
      check("t5_both_idx", bd_wr_idx, 2);
      check("t5_both_cnt2", cnt_of(2), 2);
      set_win(3, 27'h600, 27'h6FF, 27'd0);
      req_valid = 1'b1; req_addr = 32'hC000; req_data = mk(33);
      tick();
      check("t5_ch3", bd_wr_ch, 3);
      check("t5_cnt3", cnt_of(3), 1);
      req_addr = 32'hC020; bd_consume = 4'b1000;
      tick();
      req_valid = 1'b0; bd_consume = 4'b0000;
      check("t5_ovf_same_cycle", err_ovf, 1);
      check("t5_ovf_errcnt", err_cnt, 4);
      check("t5_ovf_novalid", bd_wr_valid, 0);
      check("t5_cnt3_freed", cnt_of(3), 0);
      bd_consume = 4'b1000;
      tick();
      bd_consume = 4'b0000;
      check("t5_consume_empty", bd_cnt, {28'd0, 28'd2, 28'd0, 28'd2});

      // 6: inverted window, overlapping windows, reset while valid
      set_win(1, 27'h700, 27'h6FF, 27'd5);
      req_valid = 1'b1; req_addr = 32'hE000;
      tick();
      req_valid = 1'b0;
      check("t6_inverted_miss", err_miss, 1);
      check("t6_inverted_errcnt", err_cnt, 5);
      set_win(2, 27'h100, 27'h1FF, 27'd7);
      bd_wr_ready = 1'b0;
      req_valid = 1'b1; req_addr = 32'h3000; req_data = mk(40);
      tick();
      req_valid = 1'b0;
      check("t6_overlap_ch", bd_wr_ch, 0);
      check("t6_overlap_idx", bd_wr_idx, 27'h80);
      check("t6_overlap_cnt0", cnt_of(0), 3);
      user_reset = 1'b1;
      #1;
      check("t6_rst_ready", req_ready, 0);
      tick();
      user_reset = 1'b0;
      check("t6_rst_valid", bd_wr_valid, 0);
      check("t6_rst_ch_idx", {bd_wr_ch, bd_wr_idx}, 0);
      check("t6_rst_data", bd_wr_data, 0);
      check("t6_rst_cnt", bd_cnt, 0);
      check("t6_rst_errs", {err_cnt, err_miss, err_ovf}, 0);
      #1;
      check("t6_rst_ready_back", req_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
